// File: rtl/pi_ctrl_pkg.sv
// Shared definitions for the lane-permutation round controller:
// state encoding, default limits and strobe-vector bit positions.
package pi_ctrl_pkg;

    localparam int NUM_STEPS_DEF = 24;
    localparam int MAX_RED_DEF   = 4;
    localparam int CNT_W_DEF     = 5;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_INIT  = 4'd1,
        ST_READ  = 4'd2,
        ST_LATCH = 4'd3,
        ST_REDJ  = 4'd4,
        ST_REDI  = 4'd5,
        ST_WRITE = 4'd6,
        ST_UPD   = 4'd7,
        ST_FIN   = 4'd8,
        ST_ERR   = 4'd9
    } state_e;

    localparam int SB_IJEN     = 12;
    localparam int SB_INITLINE = 11;
    localparam int SB_READ     = 10;
    localparam int SB_WRITEVAL = 9;
    localparam int SB_IJREGEN  = 8;
    localparam int SB_FB3J     = 7;
    localparam int SB_FBEQ     = 6;
    localparam int SB_ISARITH  = 5;
    localparam int SB_ENABLE   = 4;
    localparam int SB_ALUOP    = 3;
    localparam int SB_WRITE    = 2;
    localparam int SB_UPDATE   = 1;
    localparam int SB_FINISHED = 0;
    localparam int SB_W        = 13;

endpackage

// File: rtl/pi_round_controller_if.sv
// Control/status bundle between the round controller (master) and the
// top level plus permutation datapath (slave).
interface pi_round_controller_if #(
    parameter int CNT_W = 5
);
    import pi_ctrl_pkg::*;

    // start is a request held until ready is seen; it is only honoured
    // on a cycle where ready=1, otherwise it is ignored.
    logic             start;
    logic             ready;
    logic             busy;
    logic             finished;
    logic             error;
    logic [CNT_W-1:0] step_count;
    logic             IJen, initLine, read, writeVal, IJregen;
    logic             fb3j, fbeq, isArith, enable, ALUop, write, update;
    logic             sign3j, signeq, sign, eq, done;
    state_e           dbg_state;

    modport master (
        input  start, sign3j, signeq, sign, eq, done,
        output ready, busy, finished, error, step_count,
        output IJen, initLine, read, writeVal, IJregen,
        output fb3j, fbeq, isArith, enable, ALUop, write, update,
        output dbg_state
    );

    modport slave (
        output start, sign3j, signeq, sign, eq, done,
        input  ready, busy, finished, error, step_count,
        input  IJen, initLine, read, writeVal, IJregen,
        input  fb3j, fbeq, isArith, enable, ALUop, write, update,
        input  dbg_state
    );

endinterface

// File: rtl/pi_red_counter.sv
// Saturating cycle counter bounding one mod-5 reduction loop.
module pi_red_counter #(
    parameter int MAX_RED = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic at_max
);
    localparam int W = (MAX_RED > 1) ? $clog2(MAX_RED) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign at_max = (cnt_q == W'(MAX_RED - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !at_max) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pi_round_controller.sv
// Sequencer for the 5x5 lane-permutation datapath: init, per-step
// read/latch/reduce/write/update, bounded by a step and reduction budget.
module pi_round_controller
    import pi_ctrl_pkg::*;
#(
    parameter int NUM_STEPS = NUM_STEPS_DEF,
    parameter int MAX_RED   = MAX_RED_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    pi_round_controller_if.master bus
);
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  step_q, step_d;
    logic              error_q, error_d;
    logic [SB_W-1:0]   sb_q, sb_d;
    logic              red_clr, red_inc, red_at_max, start_acc;

    pi_red_counter #(.MAX_RED(MAX_RED)) u_red (
        .clk    (clk),
        .rst    (rst),
        .clr    (red_clr),
        .inc    (red_inc),
        .at_max (red_at_max)
    );

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        red_clr   = 1'b0;
        red_inc   = 1'b0;
        start_acc = 1'b0;
        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (bus.start) begin
                    start_acc = 1'b1;
                    step_d    = '0;
                    state_d   = ST_INIT;
                end
            end
            ST_INIT:  state_d = ST_READ;
            ST_READ:  state_d = ST_LATCH;
            ST_LATCH: begin
                red_clr = 1'b1;
                state_d = ST_REDJ;
            end
            ST_REDJ: begin
                if (bus.sign) begin
                    red_clr = 1'b1;
                    state_d = ST_REDI;
                end else if (red_at_max) begin
                    state_d = ST_ERR;
                end else begin
                    red_inc = 1'b1;
                end
            end
            ST_REDI: begin
                if (bus.signeq) begin
                    state_d = ST_WRITE;
                end else if (red_at_max) begin
                    state_d = ST_ERR;
                end else begin
                    red_inc = 1'b1;
                end
            end
            ST_WRITE: state_d = ST_UPD;
            ST_UPD: begin
                step_d = step_q + CNT_W'(1);
                // done beats budget exhaustion on the same step
                if (bus.done) begin
                    state_d = ST_FIN;
                end else if (step_q + CNT_W'(1) == CNT_W'(NUM_STEPS)) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        error_d = error_q;
        if (state_d == ST_ERR) begin
            error_d = 1'b1;
        end else if (start_acc) begin
            error_d = 1'b0;
        end

        // Strobes are decoded from the next state so they register alongside it
        sb_d = '0;
        case (state_d)
            ST_INIT: begin
                sb_d[SB_IJEN]     = 1'b1;
                sb_d[SB_INITLINE] = 1'b1;
            end
            ST_READ: begin
                sb_d[SB_READ]     = 1'b1;
                sb_d[SB_WRITEVAL] = 1'b1;
            end
            ST_LATCH: sb_d[SB_IJREGEN] = 1'b1;
            ST_REDJ: begin
                sb_d[SB_ALUOP] = 1'b1;
                sb_d[SB_FB3J]  = (state_q == ST_REDJ);
            end
            ST_REDI: begin
                sb_d[SB_ALUOP]   = 1'b1;
                sb_d[SB_ISARITH] = 1'b1;
                sb_d[SB_ENABLE]  = 1'b1;
                sb_d[SB_FBEQ]    = (state_q == ST_REDI);
            end
            ST_WRITE: sb_d[SB_WRITE]    = 1'b1;
            ST_UPD:   sb_d[SB_UPDATE]   = 1'b1;
            ST_FIN:   sb_d[SB_FINISHED] = 1'b1;
            default:  sb_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            error_q <= 1'b0;
            sb_q    <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            error_q <= error_d;
            sb_q    <= sb_d;
        end
    end

    assign bus.ready      = (state_q == ST_IDLE) || (state_q == ST_ERR);
    assign bus.busy       = !((state_q == ST_IDLE) || (state_q == ST_ERR));
    assign bus.error      = error_q;
    assign bus.step_count = step_q;
    assign bus.dbg_state  = state_q;
    assign bus.IJen       = sb_q[SB_IJEN];
    assign bus.initLine   = sb_q[SB_INITLINE];
    assign bus.read       = sb_q[SB_READ];
    assign bus.writeVal   = sb_q[SB_WRITEVAL];
    assign bus.IJregen    = sb_q[SB_IJREGEN];
    assign bus.fb3j       = sb_q[SB_FB3J];
    assign bus.fbeq       = sb_q[SB_FBEQ];
    assign bus.isArith    = sb_q[SB_ISARITH];
    assign bus.enable     = sb_q[SB_ENABLE];
    assign bus.ALUop      = sb_q[SB_ALUOP];
    assign bus.write      = sb_q[SB_WRITE];
    assign bus.update     = sb_q[SB_UPDATE];
    assign bus.finished   = sb_q[SB_FINISHED];

endmodule
